// File: rtl/systolic_matmul.sv
// Output-stationary N x N systolic matrix multiplier: C = A*B (or C += A*B) streamed
// one K-beat per handshake, with results drained one row at a time over valid/ready.
module systolic_matmul #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int KMAX       = 16,
  localparam int KW        = $clog2(KMAX + 1),
  localparam int RW        = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    signed_mode,
  input  logic                    acc_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_col,
  input  logic [N*DATA_WIDTH-1:0] b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*ACC_WIDTH-1:0]  out_row,
  output logic [RW-1:0]           out_row_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);
  // state | meaning
  // IDLE  | waiting for start; outputs quiet
  // LOAD  | accepting k_len operand beats (in_ready high)
  // FLUSH | 2N-1 cycles letting the last skewed beat reach PE(N-1,N-1)
  // DRAIN | presenting result rows 0..N-1 on the output handshake

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t        state;
  logic [KW-1:0] k_rem;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_q;
  logic          signed_q;
  logic          acc_mode_q;
  logic          first_q;
  logic          beat;
  logic          acc_clr;

  assign beat    = in_valid && in_ready;
  assign acc_clr = first_q && !acc_mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k_rem      <= '0;
      flush_cnt  <= '0;
      row_q      <= '0;
      signed_q   <= 1'b0;
      acc_mode_q <= 1'b0;
      first_q    <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      first_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_rem      <= k_len;
            signed_q   <= signed_mode;
            acc_mode_q <= acc_mode;
            first_q    <= 1'b1;
            busy       <= 1'b1;
            if (k_len == '0) begin
              state     <= S_DRAIN;
              out_valid <= 1'b1;
              row_q     <= '0;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (beat) begin
            k_rem <= k_rem - KW'(1);
            if (k_rem == KW'(1)) begin
              state     <= S_FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= FLUSH_LAST;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
            row_q     <= '0;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (row_q == ROW_LAST) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Input skew: lane i reaches row/column i after i cycles, tag travelling alongside.
  logic [N-1:0][DW-1:0] a_in;
  logic [N-1:0][DW-1:0] b_in;
  logic [N-1:0]         in_v;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_in[0] = a_col[DW-1:0];
      assign b_in[0] = b_row[DW-1:0];
      assign in_v[0] = beat;
    end else begin : g_delay
      logic [DW-1:0] a_sr [i];
      logic [DW-1:0] b_sr [i];
      logic          v_sr [i];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
            v_sr[d] <= 1'b0;
          end
        end else begin
          a_sr[0] <= a_col[i*DW +: DW];
          b_sr[0] <= b_row[i*DW +: DW];
          v_sr[0] <= beat;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
            v_sr[d] <= v_sr[d-1];
          end
        end
      end

      assign a_in[i] = a_sr[i-1];
      assign b_in[i] = b_sr[i-1];
      assign in_v[i] = v_sr[i-1];
    end
  end

  // PE mesh: a_h carries A rightwards between columns, b_v carries B downwards between rows.
  logic [N-1:0][N-2:0][DW-1:0] a_h;
  logic [N-1:0][N-2:0]         a_hv;
  logic [N-2:0][N-1:0][DW-1:0] b_v;
  logic [N-2:0][N-1:0]         b_vv;

  logic [N-1:0][N-1:0][DW-1:0] a_pe;
  logic [N-1:0][N-1:0][DW-1:0] b_pe;
  logic [N-1:0][N-1:0]         a_pe_v;
  logic [N-1:0][N-1:0]         b_pe_v;
  logic [N-1:0][N-1:0][AW-1:0] prod;
  logic [N-1:0][N-1:0][AW-1:0] acc;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [AW-1:0] a_ext;
      logic [AW-1:0] b_ext;

      if (j == 0) begin : g_a_edge
        assign a_pe[i][j]   = a_in[i];
        assign a_pe_v[i][j] = in_v[i];
      end else begin : g_a_mesh
        assign a_pe[i][j]   = a_h[i][j-1];
        assign a_pe_v[i][j] = a_hv[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_pe[i][j]   = b_in[j];
        assign b_pe_v[i][j] = in_v[j];
      end else begin : g_b_mesh
        assign b_pe[i][j]   = b_v[i-1][j];
        assign b_pe_v[i][j] = b_vv[i-1][j];
      end

      // Extending operands to AW before multiplying yields the extended 2*DW product mod 2^AW.
      assign a_ext = {{(AW-DW){a_pe[i][j][DW-1] & signed_q}}, a_pe[i][j]};
      assign b_ext = {{(AW-DW){b_pe[i][j][DW-1] & signed_q}}, b_pe[i][j]};
      assign prod[i][j] = a_ext * b_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_h  <= '0;
      a_hv <= '0;
      b_v  <= '0;
      b_vv <= '0;
      acc  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          a_h[i][j]  <= a_pe[i][j];
          a_hv[i][j] <= a_pe_v[i][j];
        end
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) begin
          b_v[i][j]  <= b_pe[i][j];
          b_vv[i][j] <= b_pe_v[i][j];
        end
      end
      // Clearing is folded into the first job cycle, so a beat landing there starts from zero.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (acc_clr) begin
            acc[i][j] <= (a_pe_v[i][j] && b_pe_v[i][j]) ? prod[i][j] : '0;
          end else if (a_pe_v[i][j] && b_pe_v[i][j]) begin
            acc[i][j] <= acc[i][j] + prod[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*AW +: AW] = acc_clr ? '0 : acc[row_q][j];
      end
    end
  end

  assign out_row_idx = out_valid ? row_q : '0;
  assign out_last    = out_valid && (row_q == ROW_LAST);

endmodule

// File: tb/tb_systolic_matmul.sv
// Scoreboard bench for systolic_matmul: a plain-arithmetic matrix model predicts every
// result row; a monitor pops and compares whenever a row handshakes.
module tb_systolic_matmul;
  localparam int N    = 3;
  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int KMAX = 16;
  localparam int KW   = 5;
  localparam int RW   = 2;
  localparam longint AMASK = (longint'(1) << AW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            acc_mode;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_row;
  logic [RW-1:0]   out_row_idx;
  logic            out_last;
  logic            busy;
  logic            done;

  systolic_matmul #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col),
    .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N*AW-1:0] row;
    int              idx;
  } exp_t;

  exp_t        sb[$];
  longint      c_model[N][N];
  logic [DW-1:0] a_mat[N][KMAX];
  logic [DW-1:0] b_mat[KMAX][N];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint opv(input logic [DW-1:0] x, input bit sm);
    return sm ? longint'($signed(x)) : longint'(x);
  endfunction

  // C = (am ? C : 0) + A*B, wrapped to AW bits; rows queued in drain order.
  task automatic model_job(input int k, input bit sm, input bit am);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!am) c_model[i][j] = 0;
        for (int kk = 0; kk < k; kk++)
          c_model[i][j] += opv(a_mat[i][kk], sm) * opv(b_mat[kk][j], sm);
        c_model[i][j] &= AMASK;
      end
    end
    for (int r = 0; r < N; r++) begin
      e.row = '0;
      for (int j = 0; j < N; j++) e.row[j*AW +: AW] = c_model[r][j][AW-1:0];
      e.idx = r;
      sb.push_back(e);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit              hold = 1'b0;
  logic [N*AW-1:0] h_row;
  logic [RW-1:0]   h_idx;
  logic            h_last;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (hold) begin
        check("stall_row_stable", out_row, h_row);
        check("stall_idx_stable", out_row_idx, h_idx);
        check("stall_last_stable", out_last, h_last);
      end
      if (out_ready) begin
        hold = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row actual_idx=%0d required=none", out_row_idx);
        end else begin
          e = sb.pop_front();
          check("row_data", out_row, e.row);
          check("row_idx", out_row_idx, e.idx);
          check("row_last", out_last, (e.idx == N - 1) ? 1 : 0);
        end
      end else begin
        hold   = 1'b1;
        h_row  = out_row;
        h_idx  = out_row_idx;
        h_last = out_last;
      end
    end else begin
      hold = 1'b0;
      check("quiet_outputs_zero", {out_row, out_row_idx, out_last}, 0);
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // gap: 0 continuous, 1 alternate, 2 random bubbles. stl: ready pattern. abort_at >= 0 resets mid-LOAD.
  task automatic run_job(input int k, input bit sm, input bit am, input int gap, input int stl,
                         input bit poke, input int abort_at);
    int beats, it, n, c0;
    bit v, taken, got;
    stall_mode = stl;
    if (abort_at < 0) model_job(k, sm, am);
    @(posedge clk);
    #1;
    start = 1'b1; k_len = KW'(k); signed_mode = sm; acc_mode = am;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    beats = 0;
    it = 0;
    while (beats < k && it < 4000) begin
      if (abort_at >= 0 && beats == abort_at) break;
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (it % 2 == 0) : ($urandom_range(0, 3) != 0);
      in_valid = v;
      for (int l = 0; l < N; l++) begin
        a_col[l*DW +: DW] = v ? a_mat[l][beats] : DW'($urandom_range(0, 255));
        b_row[l*DW +: DW] = v ? b_mat[beats][l] : DW'($urandom_range(0, 255));
      end
      taken = v && in_ready;
      @(posedge clk);
      #1;
      if (taken) beats++;
      it++;
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
    check("load_beats", beats, (abort_at >= 0) ? abort_at : k);
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_quiet("after_abort");
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) c_model[i][j] = 0;
      return;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (poke && n == 0) start = 1'b1;
      if (poke && n == 2) start = 1'b0;
      if (done) got = 1'b1;
      n++;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (got) begin
      check("busy_low_at_done", busy, 0);
      if (gap == 0 && stl == 0)
        check("done_cycle", cyc - c0 + 1, (k == 0) ? (N + 1) : (1 + k + 2 * N - 1 + N));
    end
  endtask

  task automatic load_req037();
    int av[3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    int bv[3][3] = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_mat[i][j] = DW'(av[i][j]);
        b_mat[i][j] = DW'(bv[i][j]);
      end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; acc_mode = 1'b0;
    in_valid = 1'b0; a_col = '0; b_row = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_model[i][j] = 0;
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        a_mat[i][kk] = '0;
        b_mat[kk][i] = '0;
      end

    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("after_reset");

    // 3x3 reference product, then accumulate (doubled), then clear again
    load_req037();
    run_job(3, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    run_job(3, 1'b0, 1'b1, 0, 0, 1'b0, -1);
    run_job(3, 1'b0, 1'b0, 0, 0, 1'b0, -1);

    // 0xFF * 2 as signed (-2) and unsigned (510)
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        a_mat[i][kk] = '0;
        b_mat[kk][i] = '0;
      end
    a_mat[0][0] = 8'hFF;
    b_mat[0][0] = 8'd2;
    run_job(1, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    run_job(1, 1'b0, 1'b0, 0, 0, 1'b0, -1);

    // bubbles on alternate cycles, 2-cycle stalls per row, stray start while busy
    load_req037();
    run_job(3, 1'b0, 1'b0, 1, 1, 1'b1, -1);

    // reset after two beats, then an empty job that keeps (now zero) accumulators
    run_job(3, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    run_job(0, 1'b0, 1'b1, 0, 0, 1'b0, -1);

    for (int t = 0; t < 10; t++) begin
      int k;
      k = (t == 0) ? KMAX : (t == 1) ? 1 : int'($urandom_range(1, KMAX));
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < KMAX; kk++) begin
          a_mat[i][kk] = DW'($urandom_range(0, 255));
          b_mat[kk][i] = DW'($urandom_range(0, 255));
        end
      run_job(k, 1'($urandom_range(0, 1)), (t == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
              (t < 3) ? 0 : 2, (t < 3) ? 0 : 2, 1'b0, -1);
    end

    stall_mode = 0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (N x N output-stationary PEs), N >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-003 SHALL have parameter ACC_WIDTH, default 20, accumulator/result width, >= 2*DATA_WIDTH.
REQ-004 SHALL have parameter KMAX, default 16, maximum inner dimension; KW = $clog2(KMAX+1).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1  begin job; sampled only in IDLE.
REQ-008 SHALL have port k_len  in  KW  inner dimension K, latched on accepted start.
REQ-009 SHALL have port signed_mode  in  1  1 = two's-complement operands, latched on start.
REQ-010 SHALL have port acc_mode  in  1  1 = keep prior accumulators, 0 = clear, latched on start.
REQ-011 SHALL have port in_valid / in_ready  in / out  1 / 1  operand beat handshake.
REQ-012 SHALL have port a_col  in  N*DATA_WIDTH  column k of A; lane i = A[i][k].
REQ-013 SHALL have port b_row  in  N*DATA_WIDTH  row k of B; lane j = B[k][j].
REQ-014 SHALL have port out_valid / out_ready  out / in  1 / 1  result row handshake.
REQ-015 SHALL have port out_row  out  N*ACC_WIDTH  lane j = C[r][j].
REQ-016 SHALL have port out_row_idx  out  $clog2(N)  row index r.
REQ-017 SHALL have port out_last  out  1  high with row N-1.
REQ-018 SHALL have port busy / done  out / out  1 / 1  not IDLE / one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE; done pulses on the DRAIN->IDLE cycle.
REQ-020 SHALL leave IDLE only on start=1; start outside IDLE SHALL be ignored.
REQ-021 SHALL clear all accumulators on accepted start when acc_mode=0, retain them when acc_mode=1.
REQ-022 SHALL, if k_len=0, go IDLE -> DRAIN directly (FLUSH skipped).
REQ-023 SHALL assert in_ready only in LOAD; each in_valid&&in_ready is one beat k; LOAD ends after k_len beats.
REQ-024 SHALL skew internally: lane i of a_col delayed i cycles into row i, lane j of b_row delayed j cycles into column j; caller supplies unskewed data.
REQ-025 SHALL propagate a valid tag with every skewed operand; cycles with in_valid=0 in LOAD insert bubbles (valid=0) and SHALL NOT alter any accumulator.
REQ-026 SHALL pass A right and B down one PE per cycle; PE(i,j) accumulates A*B only when both incoming tags valid.
REQ-027 SHALL stay in FLUSH exactly 2N-1 cycles after the last accepted beat, then enter DRAIN.
REQ-028 SHALL form products as 2*DATA_WIDTH sign- (signed_mode=1) or zero-extended (0) values, extended to ACC_WIDTH, accumulated modulo 2^ACC_WIDTH (wrap, no saturation).
REQ-029 SHALL, in DRAIN, present rows r=0..N-1 in order; out_valid high throughout DRAIN; row advances only on out_valid&&out_ready.
REQ-030 SHALL hold out_row, out_row_idx, out_last stable while out_valid=1 and out_ready=0.
REQ-031 SHALL drive out_row, out_row_idx, out_last to 0 when out_valid=0.
REQ-032 SHALL give throughput of one row per cycle with out_ready=1; done asserts the cycle after the out_last handshake.
REQ-033 SHALL, with continuous in_valid and out_ready, assert done exactly 1 + K + (2N-1) + N cycles after the start cycle.

Reset
REQ-034 SHALL, on rst=1 at any state including mid-LOAD/DRAIN, next cycle be IDLE with all accumulators, skew registers and valid tags 0.
REQ-035 SHALL hold in_ready, out_valid, out_row, out_row_idx, out_last, busy, done at 0 during and after reset until start.
REQ-036 SHALL clear latched k_len, signed_mode, acc_mode to 0 on reset.

Verification
REQ-037 N=3, K=3, unsigned, A=[[1,2,3],[4,5,6],[7,8,9]], B=[[9,8,7],[6,5,4],[3,2,1]] -> rows [30,24,18],[84,69,54],[138,114,90], out_last on row 2, done at cycle 1+3+5+3.
REQ-038 N=3, K=1, a_col lane0=0xFF, b_row lane0=2: signed_mode=1 -> C[0][0]=-2 (all ones in ACC_WIDTH); signed_mode=0 -> 510.
REQ-039 Repeat REQ-037 with second job acc_mode=1 -> every element doubled (60,48,36,...); third job acc_mode=0 -> original values.
REQ-040 REQ-037 with in_valid low on alternate cycles and out_ready low 2 cycles per row -> identical results, rows held stable while stalled.
REQ-041 rst pulsed after 2 LOAD beats, then K=0 job with acc_mode=1 -> N rows of all zeros, done after N drain cycles.
